parity_check_arbiter: RTL and testbench
=======================================

Name: parity_check_arbiter

Overview:
- Shares one 8-bit parity-check datapath among NREQ requesters.
- Each requester presents a data byte and its received parity bit.
- Arbitration is round-robin. The block captures the winner's byte, computes the XOR-reduction parity, compares it against the supplied bit, and returns a one-cycle done pulse with the requester ID and an error flag.
- Maintains a saturating global error counter.
- Sits between byte-producing front ends (serial receivers, FIFOs) and error-handling logic.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NREQ.
- DW, 8, data byte width per requester.
- CNT_W, 8, error counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request; held high until gnt seen.
- data  in  NREQ*DW  packed bytes; requester i at bits [i*DW +: DW].
- exp_par  in  NREQ  received parity bit per requester.
- odd_mode  in  1  0 = even parity, 1 = odd parity; sampled at capture.
- clr_cnt  in  1  synchronous clear of err_cnt.
- unlock  in  1  releases LOCK state (optional feature only).
- gnt  out  NREQ  one-hot grant, one-cycle pulse.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle result-valid pulse.
- done_id  out  ID_W  requester ID for current done.
- err  out  1  parity mismatch; qualified by done.
- err_cnt  out  CNT_W  saturating count of errors.
- locked  out  1  high in LOCK state.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - gnt = 0, done = 0, done_id = 0, err = 0, err_cnt = 0, locked = 0, busy = 0.
  - Round-robin pointer ptr = NREQ-1, so req[0] has top priority after reset.
  - Assertion mid-operation aborts any capture/check; no done is issued for it.
- FSM states: IDLE, CHECK, RESP (plus LOCK with the optional feature).
- IDLE:
  - If any req is high at a clock edge, the winner is the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
  - On that edge: capture the winner's byte, its exp_par, odd_mode and its ID. Set ptr to the winner and gnt to onehot(winner). Go to CHECK.
  - If no req, stay in IDLE.
- CHECK (gnt high this cycle only):
  - On the next edge: gnt = 0 and err_r = (^byte) ^ exp_par ^ odd_mode. Go to RESP.
  - Even mode: a correct byte plus parity bit has an even total count of ones.
- RESP:
  - done = 1, done_id = captured ID, err = err_r for exactly this cycle.
  - If err_r = 1, err_cnt increments. It saturates at 2**CNT_W-1; no wrap.
  - Next state is IDLE (or LOCK, see optional feature).
- Latency: req sampled at edge k → gnt high during cycle k+1 → done high during cycle k+2. One check per 3 cycles maximum.
- Requesters:
  - Must hold req, data and exp_par stable until they observe gnt.
  - Must drop req after gnt unless they have another byte.
  - A req still high in IDLE after its own grant is treated as a new request; round-robin ensures other requesters are served first.
- Boundary cases:
  - req changes during CHECK/RESP: ignored; only sampled in IDLE.
  - clr_cnt coincides with an increment: clear wins, err_cnt = 0.
  - clr_cnt is honoured in every state.
  - Single requester continuously requesting: granted every 3 cycles.
  - All requesters requesting: grants rotate 0,1,2,3,0...
- busy = (state != IDLE).
- gnt, done, done_id and err are registered outputs (no combinational path from inputs).

Optional Feature:
- Macro: PARITY_CHECK_ARBITER_LOCK_EN.
- Defined:
  - After a RESP with err = 1, the FSM enters LOCK instead of IDLE. locked = 1 and no grants are issued.
  - A cycle with unlock = 1 in LOCK returns to IDLE. locked drops on that edge.
  - Reset clears LOCK.
- Not defined:
  - No LOCK state; RESP always returns to IDLE.
  - locked is tied 0 and unlock is ignored.

Test Plan:
- Reset, then req=4'b0001, data0=8'hA5, exp_par0=0, odd_mode=0 → gnt=0001 one cycle after the sampling edge, then done=1, done_id=0, err=0, err_cnt=0.
- req0 with data0=8'h07, exp_par0=0, odd_mode=0 → done with err=1, err_cnt=1. The same byte with exp_par0=1 → err=0.
- odd_mode=1, data=8'h00, exp_par=1 → err=0; exp_par=0 → err=1.
- req=4'b1111 held, all bytes correct → gnt sequence 0001, 0010, 0100, 1000, 0001, with one grant every 3 cycles and done_id 0,1,2,3,0.
- CNT_W=2 bench, 5 errored checks → err_cnt saturates at 3. Then clr_cnt asserted in the same cycle as an errored RESP → err_cnt=0.
- rst_n pulsed low during CHECK → gnt, done and busy are 0 immediately and no done is seen. With LOCK_EN: an errored check gives locked=1 and further req are ignored; unlock=1 for one cycle → the next req is granted.

Source files
------------

// File: rtl/parity_check_arbiter.sv
// parity_check_arbiter: round-robin arbiter in front of a single shared
// parity-check datapath. The winner's byte is captured, checked against its
// parity bit in the next cycle, and the result is reported as a one-cycle
// done pulse with the requester ID and an error flag.
// Optional feature macro: PARITY_CHECK_ARBITER_LOCK_EN (errored check locks
// the arbiter until unlock is pulsed).
module parity_check_arbiter #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int DW    = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   data,
  input  logic [NREQ-1:0]      exp_par,
  input  logic                 odd_mode,
  input  logic                 clr_cnt,
  input  logic                 unlock,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 done,
  output logic [ID_W-1:0]      done_id,
  output logic                 err,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 locked
);

`ifdef PARITY_CHECK_ARBITER_LOCK_EN
  typedef enum logic [1:0] {IDLE, CHECK, RESP, LOCK} state_t;
`else
  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
`endif

  state_t          state, state_nx;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] win_id;
  logic            win_found;
  logic [DW-1:0]   cap_byte;
  logic            cap_par;
  logic            cap_odd;

  // Round-robin search: first set request starting one past the last winner.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Next-state logic; requests are only considered while idle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (win_found) state_nx = CHECK;
      CHECK: state_nx = RESP;
`ifdef PARITY_CHECK_ARBITER_LOCK_EN
      RESP:  state_nx = err ? LOCK : IDLE;
      LOCK:  if (unlock) state_nx = IDLE;
`else
      RESP:  state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Capture, check and response registers; err holds the check result for
  // the RESP cycle so the counter can use it on the closing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= ID_W'(NREQ - 1);
      gnt      <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      err      <= 1'b0;
      cap_byte <= '0;
      cap_par  <= 1'b0;
      cap_odd  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            ptr      <= win_id;
            gnt      <= NREQ'(1) << win_id;
            cap_byte <= data[win_id*DW +: DW];
            cap_par  <= exp_par[win_id];
            cap_odd  <= odd_mode;
          end
        end
        CHECK: begin
          gnt     <= '0;
          err     <= (^cap_byte) ^ cap_par ^ cap_odd;
          done    <= 1'b1;
          done_id <= ptr;
        end
        RESP: begin
          done <= 1'b0;
          err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Saturating error counter; a clear beats a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (clr_cnt)
      err_cnt <= '0;
    else if (state == RESP && err && err_cnt != '1)
      err_cnt <= err_cnt + 1'b1;
  end

  assign busy = (state != IDLE);

`ifdef PARITY_CHECK_ARBITER_LOCK_EN
  assign locked = (state == LOCK);
`else
  logic unused_unlock;
  assign unused_unlock = unlock;
  assign locked        = 1'b0;
`endif

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Self-checking bench for parity_check_arbiter (NREQ=4, CNT_W=2 so that
// counter saturation is reachable quickly).
module tb_parity_check_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int DW = 8;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ*DW-1:0] data = '0;
  logic [NREQ-1:0]  exp_par = '0;
  logic             odd_mode = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             unlock = 1'b0;
  logic [NREQ-1:0]  gnt;
  logic             busy, done, err, locked;
  logic [ID_W-1:0]  done_id;
  logic [CNT_W-1:0] err_cnt;

  int total = 0;
  int bad = 0;
  int model_ptr = NREQ - 1;
  int model_cnt = 0;

  parity_check_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .exp_par(exp_par),
    .odd_mode(odd_mode), .clr_cnt(clr_cnt), .unlock(unlock), .gnt(gnt),
    .busy(busy), .done(done), .done_id(done_id), .err(err), .err_cnt(err_cnt),
    .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference: first set request scanning upward from one past the last winner.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int off = 1; off <= NREQ; off++) begin
      if (r[(p + off) % NREQ]) return (p + off) % NREQ;
    end
    return -1;
  endfunction

  // Reference: error when the total count of ones disagrees with the mode.
  function automatic logic par_err(input logic [DW-1:0] b, input logic p, input logic o);
    int ones;
    ones = $countones(b) + int'(p);
    return (ones % 2) != int'(o);
  endfunction

  function automatic int next_cnt(input int c, input logic e, input logic clr);
    if (clr) return 0;
    if (e && c < CNT_MAX) return c + 1;
    return c;
  endfunction

  // One full transaction starting at a negedge while idle; observation only.
  task automatic run_txn(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d,
                         input logic [NREQ-1:0] p, input logic o, input logic clr,
                         output logic [NREQ-1:0] g, output logic g_done, output logic g_busy,
                         output logic dn, output logic [ID_W-1:0] id, output logic e,
                         output logic [CNT_W-1:0] cnt, output logic dn_after);
    req = r; data = d; exp_par = p; odd_mode = o;
    @(negedge clk);
    g = gnt; g_done = done; g_busy = busy;
    @(negedge clk);
    dn = done; id = done_id; e = err;
    clr_cnt = clr;
    @(negedge clk);
    clr_cnt = 1'b0;
    cnt = err_cnt; dn_after = done;
`ifdef PARITY_CHECK_ARBITER_LOCK_EN
    if (e) begin
      unlock = 1'b1;
      @(negedge clk);
      unlock = 1'b0;
    end
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (err !== 1'b0 || done_id !== 2'd0) begin bad++; $display("FAIL reset_err_id got=%b/%0d exp=0/0", err, done_id); end
    total++; if (err_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", err_cnt); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    rst_n = 1'b1;
    model_ptr = NREQ - 1;
    model_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0] p, g;
    logic gd, gb, dn, e, da;
    logic [ID_W-1:0] id;
    logic [CNT_W-1:0] c;
    for (int k = 0; k < 5; k++) begin
      d = {$urandom, $urandom};
      for (int i = 0; i < NREQ; i++) p[i] = ^d[i*DW +: DW];
      run_txn(4'b1111, d, p, 1'b0, 1'b0, g, gd, gb, dn, id, e, c, da);
      model_ptr = k % NREQ;
      total++; if (g !== (4'b0001 << (k % NREQ))) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, g, 4'b0001 << (k % NREQ)); end
      total++; if (dn !== 1'b1 || id !== 2'(k % NREQ)) begin bad++; $display("FAIL rr_done[%0d] got=%b/%0d exp=1/%0d", k, dn, id, k % NREQ); end
      total++; if (e !== 1'b0 || gd !== 1'b0 || da !== 1'b0) begin bad++; $display("FAIL rr_err_pulse[%0d] got=%b%b%b exp=000", k, e, gd, da); end
    end
    req = '0;
  endtask

  task automatic test_directed;
    logic [7:0] tb_byte [5] = '{8'hA5, 8'h07, 8'h07, 8'h00, 8'h00};
    logic       tb_par  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       tb_odd  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       tb_err  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [NREQ-1:0] g;
    logic gd, gb, dn, e, da;
    logic [ID_W-1:0] id;
    logic [CNT_W-1:0] c;
    for (int k = 0; k < 5; k++) begin
      run_txn(4'b0001, {24'h0, tb_byte[k]}, {3'b000, tb_par[k]}, tb_odd[k], 1'b0,
              g, gd, gb, dn, id, e, c, da);
      model_ptr = 0;
      model_cnt = next_cnt(model_cnt, tb_err[k], 1'b0);
      total++; if (g !== 4'b0001 || gb !== 1'b1) begin bad++; $display("FAIL dir_gnt[%0d] got=%b busy=%b exp=0001 busy=1", k, g, gb); end
      total++; if (dn !== 1'b1 || id !== 2'd0 || e !== tb_err[k]) begin bad++; $display("FAIL dir_result[%0d] got=%b/%0d/%b exp=1/0/%b", k, dn, id, e, tb_err[k]); end
      total++; if (c !== 2'(model_cnt)) begin bad++; $display("FAIL dir_cnt[%0d] got=%0d exp=%0d", k, c, model_cnt); end
    end
    req = '0;
  endtask

  task automatic test_saturation;
    logic [NREQ-1:0] g;
    logic gd, gb, dn, e, da;
    logic [ID_W-1:0] id;
    logic [CNT_W-1:0] c;
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    model_cnt = 0;
    total++; if (err_cnt !== 2'd0) begin bad++; $display("FAIL sat_idle_clear got=%0d exp=0", err_cnt); end
    for (int k = 0; k < 6; k++) begin
      run_txn(4'b0001, {24'h0, 8'h07}, 4'b0000, 1'b0, k == 5, g, gd, gb, dn, id, e, c, da);
      model_ptr = 0;
      model_cnt = next_cnt(model_cnt, 1'b1, k == 5);
      total++; if (e !== 1'b1 || c !== 2'(model_cnt)) begin bad++; $display("FAIL sat_cnt[%0d] got=%b/%0d exp=1/%0d", k, e, c, model_cnt); end
    end
    req = '0;
  endtask

  task automatic test_random;
    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0] r, p, g;
    logic o, clr, gd, gb, dn, e, da, e_exp;
    logic [ID_W-1:0] id;
    logic [CNT_W-1:0] c;
    int w;
    for (int k = 0; k < 40; k++) begin
      r = 4'($urandom_range(1, 15));
      d = {$urandom, $urandom};
      p = 4'($urandom);
      o = 1'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      run_txn(r, d, p, o, clr, g, gd, gb, dn, id, e, c, da);
      w = pick(r, model_ptr);
      model_ptr = w;
      e_exp = par_err(d[w*DW +: DW], p[w], o);
      model_cnt = next_cnt(model_cnt, e_exp, clr);
      total++; if (g !== (4'b0001 << w)) begin bad++; $display("FAIL rnd_gnt[%0d] req=%b got=%b exp=%b", k, r, g, 4'b0001 << w); end
      total++; if (dn !== 1'b1 || id !== 2'(w) || e !== e_exp) begin bad++; $display("FAIL rnd_result[%0d] got=%b/%0d/%b exp=1/%0d/%b", k, dn, id, e, w, e_exp); end
      total++; if (c !== 2'(model_cnt) || da !== 1'b0) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d done_after=%b exp=%0d/0", k, c, da, model_cnt); end
    end
    req = '0;
  endtask

  task automatic test_reset_mid;
    logic [NREQ-1:0] g;
    logic gd, gb, dn, e, da, seen;
    logic [ID_W-1:0] id;
    logic [CNT_W-1:0] c;
    req = 4'b0100; data = {$urandom, $urandom}; exp_par = 4'b0000;
    @(negedge clk);
    total++; if (gnt !== 4'b0100 && model_ptr != 2) begin bad++; $display("FAIL mid_pre_gnt got=%b exp=0100", gnt); end
    rst_n = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_reset_outputs got=%b/%b/%b exp=0000/0/0", gnt, done, busy); end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = NREQ - 1;
    model_cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%b exp=0", seen); end
    run_txn(4'b1111, 64'h0, 4'b0000, 1'b0, 1'b0, g, gd, gb, dn, id, e, c, da);
    model_ptr = 0;
    total++; if (g !== 4'b0001 || c !== 2'd0) begin bad++; $display("FAIL mid_ptr_reset got=%b cnt=%0d exp=0001 cnt=0", g, c); end
    req = '0;
  endtask

`ifdef PARITY_CHECK_ARBITER_LOCK_EN
  task automatic test_lock;
    logic any_gnt;
    req = 4'b0001; data = {56'h0, 8'h07}; exp_par = 4'b0000; odd_mode = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (locked !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL lock_enter got=%b/%b exp=1/1", locked, busy); end
    req = 4'b1111;
    any_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) any_gnt = 1'b1;
    end
    total++; if (any_gnt !== 1'b0 || locked !== 1'b1) begin bad++; $display("FAIL lock_hold got=%b/%b exp=0/1", any_gnt, locked); end
    req = 4'b0010;
    unlock = 1'b1;
    @(negedge clk);
    unlock = 1'b0;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_release got=%b exp=0", locked); end
    @(negedge clk);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL lock_next_gnt got=%b exp=0010", gnt); end
    req = '0;
    model_ptr = 1;
    model_cnt = next_cnt(model_cnt, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_directed();
    test_saturation();
    test_random();
`ifdef PARITY_CHECK_ARBITER_LOCK_EN
    test_lock();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
